// File: rtl/gravador_sequencia_pkg.sv
// Types and helpers shared by the sequence recorder and its timer.
package gravador_pkg;

  localparam int DEPTH_MAX = 16;

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    ESPERA_BOTAO = 3'd1,
    ESPERA_SOLTA = 3'd2,
    PRONTO       = 3'd3,
    REP_ON       = 3'd4,
    REP_OFF      = 3'd5
  } estado_t;

  // Status flags that follow the state; kept registered next to the state.
  typedef struct packed {
    logic       gravando;
    logic       reproduzindo;
    logic       pronto;
    logic [3:0] db_estado;
  } saidas_t;

  // True when exactly one button is pressed.
  function automatic logic um_quente(input logic [3:0] b);
    return (b != 4'b0000) && ((b & (b - 4'd1)) == 4'b0000);
  endfunction

  function automatic saidas_t saidas_de(input estado_t e);
    saidas_t s;
    s.gravando     = (e == ESPERA_BOTAO) || (e == ESPERA_SOLTA);
    s.reproduzindo = (e == REP_ON) || (e == REP_OFF);
    s.pronto       = (e == PRONTO);
    s.db_estado    = {1'b0, e};
    return s;
  endfunction

endpackage

// File: rtl/gravador_sequencia_if.sv
// Control, button, read-port and status bundle between the game and the recorder.
interface gravador_sequencia_if #(parameter int AW = 4);
  logic          iniciar;
  logic          finalizar;
  logic          reproduzir;
  logic [3:0]    botoes;
  logic [AW-1:0] rd_addr;
  logic [3:0]    rd_data;
  logic [3:0]    leds;
  logic [AW:0]   tamanho;
  logic          gravando;
  logic          reproduzindo;
  logic          pronto;
  logic          erro_botao;
  logic [3:0]    db_estado;

  modport master (
    output iniciar, finalizar, reproduzir, botoes, rd_addr,
    input  rd_data, leds, tamanho, gravando, reproduzindo, pronto, erro_botao, db_estado
  );

  modport slave (
    input  iniciar, finalizar, reproduzir, botoes, rd_addr,
    output rd_data, leds, tamanho, gravando, reproduzindo, pronto, erro_botao, db_estado
  );
endinterface

// File: rtl/gravador_sequencia_timer_pisca.sv
// Saturating down-counter used for both the lit and the dark replay phases.
// The load request arrives registered, so fim is held low during the load
// cycle; a load of N therefore ends the phase N+2 cycles after it is requested.
module timer_pisca #(
  parameter int W = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carga,
  input  logic [W-1:0] valor,
  output logic         fim
);
  logic [W-1:0] conta;

  // Load on request, otherwise count down and stop at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              conta <= '0;
    else if (carga)          conta <= valor;
    else if (conta != '0)    conta <= conta - 1'b1;
  end

  assign fim = (conta == '0) && !carga;
endmodule

// File: rtl/gravador_sequencia.sv
// Records a one-hot button sequence, replays it on the LEDs, and serves it
// through a registered read port.
//
// state        | meaning
// OCIOSO       | idle after reset, waiting for iniciar
// ESPERA_BOTAO | recording, waiting for a press (or finalizar)
// ESPERA_SOLTA | recording, waiting for all buttons released
// PRONTO       | sequence closed, waiting for iniciar or reproduzir
// REP_ON       | replay, current entry lit
// REP_OFF      | replay, LEDs dark between entries
module gravador_sequencia
  import gravador_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int T_ON  = 500,   // must be >= 2
  parameter int T_OFF = 500    // must be >= 2
) (
  input logic                  clock,
  input logic                  reset,
  gravador_sequencia_if.slave  bus
);
  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TW    = $clog2(T_MAX);

  // First lit phase carries the one-cycle entry overhead.
  localparam logic [TW-1:0] CARGA_ON_1 = TW'(T_ON - 1);
  localparam logic [TW-1:0] CARGA_ON   = TW'(T_ON - 2);
  localparam logic [TW-1:0] CARGA_OFF  = TW'(T_OFF - 2);
  localparam logic [AW:0]   CHEIO      = (AW+1)'(DEPTH);

  estado_t       estado;
  saidas_t       saidas;
  logic [3:0]    mem [DEPTH];
  logic [AW:0]   tamanho;
  logic [AW:0]   indice;
  logic [AW:0]   indice_mais1;
  logic [3:0]    leds;
  logic [3:0]    rd_data;
  logic          erro;
  logic          carga;
  logic [TW-1:0] valor;
  logic          fim;

  assign indice_mais1 = indice + 1'b1;

  timer_pisca #(.W(TW)) u_timer (
    .clock (clock),
    .reset (reset),
    .carga (carga),
    .valor (valor),
    .fim   (fim)
  );

  // Recording / replay sequencer, including the entry store.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= OCIOSO;
      saidas  <= saidas_de(OCIOSO);
      tamanho <= '0;
      indice  <= '0;
      leds    <= '0;
      erro    <= 1'b0;
      carga   <= 1'b0;
      valor   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      erro  <= 1'b0;
      carga <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (bus.iniciar) begin
            tamanho <= '0;
            estado  <= ESPERA_BOTAO;
            saidas  <= saidas_de(ESPERA_BOTAO);
          end
        end
        ESPERA_BOTAO: begin
          if (um_quente(bus.botoes)) begin
            mem[tamanho[AW-1:0]] <= bus.botoes;
            tamanho <= tamanho + 1'b1;
            estado  <= ESPERA_SOLTA;
            saidas  <= saidas_de(ESPERA_SOLTA);
          end else if (bus.botoes != 4'b0000) begin
            erro   <= 1'b1;
            estado <= ESPERA_SOLTA;
            saidas <= saidas_de(ESPERA_SOLTA);
          end else if (bus.finalizar && (tamanho != '0)) begin
            estado <= PRONTO;
            saidas <= saidas_de(PRONTO);
          end
        end
        ESPERA_SOLTA: begin
          if (bus.botoes == 4'b0000) begin
            if (tamanho == CHEIO) begin
              estado <= PRONTO;
              saidas <= saidas_de(PRONTO);
            end else begin
              estado <= ESPERA_BOTAO;
              saidas <= saidas_de(ESPERA_BOTAO);
            end
          end
        end
        PRONTO: begin
          if (bus.iniciar) begin
            tamanho <= '0;
            estado  <= ESPERA_BOTAO;
            saidas  <= saidas_de(ESPERA_BOTAO);
          end else if (bus.reproduzir) begin
            indice <= '0;
            carga  <= 1'b1;
            valor  <= CARGA_ON_1;
            estado <= REP_ON;
            saidas <= saidas_de(REP_ON);
          end
        end
        REP_ON: begin
          if (fim) begin
            leds   <= '0;
            carga  <= 1'b1;
            valor  <= CARGA_OFF;
            estado <= REP_OFF;
            saidas <= saidas_de(REP_OFF);
          end else begin
            leds <= mem[indice[AW-1:0]];
          end
        end
        REP_OFF: begin
          if (fim) begin
            indice <= indice_mais1;
            if (indice_mais1 == tamanho) begin
              estado <= PRONTO;
              saidas <= saidas_de(PRONTO);
            end else begin
              leds   <= mem[indice_mais1[AW-1:0]];
              carga  <= 1'b1;
              valor  <= CARGA_ON;
              estado <= REP_ON;
              saidas <= saidas_de(REP_ON);
            end
          end
        end
        default: begin
          estado <= OCIOSO;
          saidas <= saidas_de(OCIOSO);
        end
      endcase
    end
  end

  // Registered read port; entries past the recorded length read as zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= ({1'b0, bus.rd_addr} < tamanho) ? mem[bus.rd_addr] : 4'b0000;
  end

  assign bus.rd_data      = rd_data;
  assign bus.leds         = leds;
  assign bus.tamanho      = tamanho;
  assign bus.gravando     = saidas.gravando;
  assign bus.reproduzindo = saidas.reproduzindo;
  assign bus.pronto       = saidas.pronto;
  assign bus.db_estado    = saidas.db_estado;
  assign bus.erro_botao   = erro;
endmodule

// File: tb/tb_gravador_sequencia.sv
// Scoreboard bench for gravador_sequencia: stimulus pushes expected read data,
// LED streams and error events; a negedge monitor pops and compares them.
module tb_gravador_sequencia;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int T_ON  = 3;
  localparam int T_OFF = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rd_strobe = 1'b0;
  logic rd_strobe_d = 1'b0;

  int n_aval = 0;
  int n_falhas = 0;

  logic [3:0] q_leds[$];
  logic [3:0] q_rd[$];
  int         q_err[$];
  logic [3:0] modelo[$];
  bit         gravando_m = 1'b0;

  logic [3:0] esp_mon;
  int         tam_mon;

  always #5 clock = ~clock;

  gravador_sequencia_if #(.AW(AW)) bus ();

  gravador_sequencia #(.DEPTH(DEPTH), .AW(AW), .T_ON(T_ON), .T_OFF(T_OFF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic verifica(input string nome, input int atual, input int esperado);
    n_aval++;
    if (atual != esperado) begin
      n_falhas++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  always @(posedge clock) rd_strobe_d <= rd_strobe;

  // Monitor: consume expectations whenever the DUT presents an output.
  always @(negedge clock) begin
    if (reset) begin
      if (bus.reproduzindo) begin
        verifica("leds_stream_available", int'(q_leds.size() > 0), 1);
        if (q_leds.size() > 0) begin
          esp_mon = q_leds.pop_front();
          verifica("leds", bus.leds, esp_mon);
        end
      end
      if (rd_strobe_d) begin
        verifica("rd_expected_available", int'(q_rd.size() > 0), 1);
        if (q_rd.size() > 0) begin
          esp_mon = q_rd.pop_front();
          verifica("rd_data", bus.rd_data, esp_mon);
        end
      end
      if (bus.erro_botao) begin
        verifica("erro_expected", int'(q_err.size() > 0), 1);
        if (q_err.size() > 0) begin
          tam_mon = q_err.pop_front();
          verifica("tamanho_on_erro", bus.tamanho, tam_mon);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic zera_entradas();
    bus.iniciar = 1'b0; bus.finalizar = 1'b0; bus.reproduzir = 1'b0; bus.botoes = 4'b0000;
  endtask

  task automatic iniciar_rec();
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    modelo.delete();
    gravando_m = 1'b1;
    verifica("gravando_after_iniciar", bus.gravando, 1);
    verifica("tamanho_after_iniciar", bus.tamanho, 0);
  endtask

  task automatic pressiona(input logic [3:0] b, input bit com_fim = 1'b0);
    if (gravando_m) begin
      if ($countones(b) == 1) modelo.push_back(b);
      else if ($countones(b) >= 2) q_err.push_back(modelo.size());
    end
    bus.botoes = b;
    bus.finalizar = com_fim;
    tick();
    bus.botoes = 4'b0000;
    bus.finalizar = 1'b0;
    tick();
    if (gravando_m && modelo.size() == DEPTH) gravando_m = 1'b0;
  endtask

  task automatic fecha();
    bus.finalizar = 1'b1;
    tick();
    bus.finalizar = 1'b0;
    if (modelo.size() > 0) gravando_m = 1'b0;
    verifica("pronto_after_finalizar", bus.pronto, int'(!gravando_m));
    verifica("db_estado_after_finalizar", bus.db_estado, gravando_m ? 1 : 3);
    verifica("tamanho_after_finalizar", bus.tamanho, modelo.size());
  endtask

  task automatic le(input int addr);
    bus.rd_addr = AW'(addr);
    rd_strobe = 1'b1;
    q_rd.push_back((addr < modelo.size()) ? modelo[addr] : 4'b0000);
    tick();
    rd_strobe = 1'b0;
  endtask

  task automatic empilha_replay();
    q_leds.push_back(4'b0000);
    foreach (modelo[i]) begin
      repeat (T_ON)  q_leds.push_back(modelo[i]);
      repeat (T_OFF) q_leds.push_back(4'b0000);
    end
  endtask

  task automatic reproduz(input bit ruido);
    int n;
    n = modelo.size();
    empilha_replay();
    bus.reproduzir = 1'b1;
    tick();
    bus.reproduzir = 1'b0;
    verifica("reproduzindo_start", bus.reproduzindo, 1);
    for (int t = 0; t < (T_ON + T_OFF) * n + 20 && !bus.pronto; t++) begin
      if (ruido && t < (T_ON + T_OFF) * n - 2) begin
        bus.botoes     = 4'($urandom_range(0, 15));
        bus.iniciar    = 1'($urandom_range(0, 1));
        bus.finalizar  = 1'($urandom_range(0, 1));
        bus.reproduzir = 1'($urandom_range(0, 1));
      end else begin
        zera_entradas();
      end
      tick();
    end
    zera_entradas();
    verifica("pronto_after_replay", bus.pronto, 1);
    verifica("leds_stream_consumed", q_leds.size(), 0);
    verifica("tamanho_after_replay", bus.tamanho, modelo.size());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] b;
    int n;
    zera_entradas();
    bus.rd_addr = '0;
    tick(2);
    verifica("reset_db_estado", bus.db_estado, 0);
    verifica("reset_tamanho", bus.tamanho, 0);
    verifica("reset_leds", bus.leds, 0);
    verifica("reset_pronto", bus.pronto, 0);
    reset = 1'b1;
    tick();

    // Fixed three-entry recording, reads and replay.
    iniciar_rec();
    pressiona(4'b0001);
    pressiona(4'b0100);
    pressiona(4'b1000);
    fecha();
    verifica("tamanho_three", bus.tamanho, 3);
    le(1);
    le(3);
    le(0);
    tick();
    reproduz(1'b0);

    // Restart from PRONTO, ignored empty finalizar, error press, press+finalizar.
    iniciar_rec();
    fecha();
    verifica("gravando_after_empty_finalizar", bus.gravando, 1);
    pressiona(4'b0011);
    verifica("tamanho_after_erro", bus.tamanho, 0);
    pressiona(4'b0010, 1'b1);
    verifica("gravando_after_press_finalizar", bus.gravando, 1);
    verifica("tamanho_after_press_finalizar", bus.tamanho, 1);
    pressiona(4'b0001);
    fecha();
    le(0);
    le(1);
    le(2);
    tick();
    reproduz(1'b1);

    // Random recordings.
    for (int r = 0; r < 3; r++) begin
      iniciar_rec();
      n = $urandom_range(1, 8);
      for (int k = 0; k < n || modelo.size() == 0; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          do b = 4'($urandom_range(3, 15)); while ($countones(b) < 2);
        end else begin
          b = 4'(1 << $urandom_range(0, 3));
        end
        pressiona(b);
      end
      fecha();
      for (int k = 0; k < 6; k++) le($urandom_range(0, DEPTH - 1));
      tick();
      reproduz(1'b1);
    end

    // Full store closes itself; a 17th press is not written.
    iniciar_rec();
    for (int k = 0; k < DEPTH; k++) pressiona(4'(1 << $urandom_range(0, 3)));
    verifica("pronto_when_full", bus.pronto, 1);
    verifica("tamanho_when_full", bus.tamanho, DEPTH);
    pressiona(4'b0100);
    verifica("tamanho_after_17th", bus.tamanho, DEPTH);
    verifica("pronto_after_17th", bus.pronto, 1);
    for (int k = 0; k < DEPTH; k++) le(k);
    tick();
    reproduz(1'b1);

    // Asynchronous reset in the middle of a replay.
    empilha_replay();
    bus.reproduzir = 1'b1;
    tick();
    bus.reproduzir = 1'b0;
    tick(7);
    #2 reset = 1'b0;
    q_leds.delete();
    modelo.delete();
    gravando_m = 1'b0;
    #1;
    verifica("midreset_leds", bus.leds, 0);
    verifica("midreset_db_estado", bus.db_estado, 0);
    verifica("midreset_tamanho", bus.tamanho, 0);
    verifica("midreset_reproduzindo", bus.reproduzindo, 0);
    verifica("midreset_pronto", bus.pronto, 0);
    verifica("midreset_gravando", bus.gravando, 0);
    verifica("midreset_erro", bus.erro_botao, 0);
    verifica("midreset_rd_data", bus.rd_data, 0);
    tick();
    reset = 1'b1;
    tick();
    for (int k = 0; k < DEPTH; k++) le(k);
    tick(2);
    verifica("db_estado_idle_after_reset", bus.db_estado, 0);
    verifica("rd_queue_drained", q_rd.size(), 0);
    verifica("erro_queue_drained", q_err.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falhas);
    $finish;
  end
endmodule
